rtc_time_ascii: RTL and testbench
=================================

# rtc_time_ascii

Downstream consumer of the RTC controller's 24-bit BCD time word (`hours[23:16]`, `minutes[15:8]`, `seconds[7:0]`). It waits for a new, stable time value and emits it as an ASCII frame `HH:MM:SS` plus line terminator. The frame is sent over a byte-wide valid/ready stream that feeds the board's serial transmitter. It runs on the same 50 MHz system clock as the I2C/RTC path.

## Interface
- `SETTLE_CYCLES`, default 16'd1000 — consecutive cycles `data_in` must hold one value before capture; legal range 1..65535.
- `SEP_CHAR`, default 8'h3A (`:`) — separator byte between fields.
- `clk` input 1 — system clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `data_in` input 24 — BCD time from the RTC controller; may change at any cycle, including mid-update.
- `tx_data` output 8 — current ASCII byte.
- `tx_valid` output 1 — `tx_data` is valid.
- `tx_ready` input 1 — sink accepts the byte when `tx_valid && tx_ready`.
- `busy` output 1 — a frame is in flight; high in SEND.
- `frame_done` output 1 — one-cycle pulse on acceptance of the last byte.
- `bcd_err` output 1 — sticky; set when any captured nibble is >9; cleared only by reset.

## Operation
- States: IDLE, SEND.
- Stability tracking, active in both states:
  - `prev_in` registers `data_in` every cycle.
  - `stab_cnt` clears whenever `data_in != prev_in`; otherwise it increments and saturates at SETTLE_CYCLES-1.
- IDLE → SEND when all of the following hold in the same cycle:
  - `stab_cnt == SETTLE_CYCLES-1`
  - `data_in == prev_in`
  - `data_in != last_sent`
- On that transition, `snap <= data_in`, `idx <= 0`.
- SEND:
  - Frame byte order: H-tens, H-units, SEP, M-tens, M-units, SEP, S-tens, S-units, then the terminator.
  - `tx_data` is a function of `idx` and `snap` only, so it is stable while `tx_valid` is high.
  - On handshake, `idx <= idx+1`.
  - On the last byte's handshake: `frame_done` pulses, `last_sent <= snap`, and the FSM returns to IDLE.
- Digit conversion:
  - Nibble 0..9 → 8'h30+n.
  - Nibble >9 → 8'h3F (`?`), and `bcd_err` is set when the snapshot is taken.
- Changes to `data_in` during SEND do not affect the current frame. They are tracked and sent as a new frame after return to IDLE, once stable.
- Wrap-around 23:59:59 → 00:00:00 is an ordinary change; no special handling.
- Reset mid-frame: the frame is abandoned, all outputs go to reset values, and no partial bytes are re-sent.
- `last_sent` resets to 24'hFFFFFF, so the first stable value after reset is always sent, unless that value itself is 24'hFFFFFF (never sent; documented limitation).

## Timing
- Reset values:
  - `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `frame_done`=0, `bcd_err`=0
  - `stab_cnt`=0, `prev_in`=0, `idx`=0, state IDLE.
- Capture latency: a value applied at cycle T (differing from the prior value) is captured at the edge ending cycle T+SETTLE_CYCLES.
- `tx_valid` and `busy` rise in the cycle after capture.
- With `tx_ready` held high, one byte is accepted per cycle. `frame_done` pulses in the same cycle the last byte is accepted, and `tx_valid` is 0 in the next cycle.
- `tx_valid` never drops without a handshake. `tx_data` does not change while `tx_valid && !tx_ready`.
- Minimum inter-frame gap: 1 idle cycle (IDLE is re-evaluated after return).

## Configuration
- `RTC_TIME_ASCII_CRLF_EN` defined:
  - Terminator is 8'h0D 8'h0A.
  - Frame length is 10 bytes, `idx` 0..9.
- Not defined:
  - Terminator is 8'h0A only.
  - Frame length is 9 bytes, `idx` 0..8.
- `FRAME_LEN` is derived from the macro. No other behaviour differs.

## Structure
- Package `rtc_ascii_pkg`:
  - State typedef (IDLE, SEND).
  - ASCII constants: `ASCII_0`=8'h30, `ASCII_Q`=8'h3F, `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A.
  - `FRAME_LEN` (macro-dependent).
  - `idx` width constant (4 bits).
- Sub-module `bcd_to_ascii`: combinational; 4-bit nibble → 8-bit ASCII plus `invalid` flag. Instantiated six times on `snap`.

## Test plan
- Set `SETTLE_CYCLES`=4, hold `data_in`=24'h12_34_56, `tx_ready`=1 → capture after 4 stable cycles; bytes 31 32 3A 33 34 3A 35 36 0D 0A with CRLF_EN, 10 consecutive cycles; `frame_done` on byte 0A.
- Same stimulus, CRLF_EN undefined → 9 bytes ending 0A; no 0D.
- Toggle `data_in` every 3 cycles with `SETTLE_CYCLES`=4 → `tx_valid` stays 0. Then hold 24'h23_59_59 → one frame "23:59:59". Then 24'h00_00_00 → one frame "00:00:00".
- Backpressure: `tx_ready` low for 5 cycles at byte 3, and `data_in` changed to 24'h01_02_03 mid-frame → `tx_data`=8'h33 held, original frame completes unchanged, then a second frame "01:02:03" follows.
- `data_in`=24'h1A_00_00 → byte 1 = 8'h3F, `bcd_err`=1 and stays high. Re-presenting an identical value after the frame → no new frame.
- Assert `rst_n` low at byte 4 → `tx_valid`=0, `busy`=0 immediately. After release with the same `data_in`, a complete fresh frame starts from byte 0.

Source files
------------

// File: rtl/rtc_ascii_pkg.sv
// -----------------------------------------------------------------------------
// rtc_ascii_pkg
// Shared types and constants for the RTC time-to-ASCII framer.
//   state_e    : framer FSM states (IDLE, SEND)
//   ASCII_*    : byte constants used to build the frame
//   IDX_W      : width of the byte index within a frame
//   FRAME_LEN  : bytes per frame; 10 (CR LF terminator) when
//                RTC_TIME_ASCII_CRLF_EN is defined, otherwise 9 (LF only)
// -----------------------------------------------------------------------------
package rtc_ascii_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int IDX_W = 4;

`ifdef RTC_TIME_ASCII_CRLF_EN
  localparam logic [IDX_W-1:0] FRAME_LEN = 4'd10;
`else
  localparam logic [IDX_W-1:0] FRAME_LEN = 4'd9;
`endif

endpackage

// File: rtl/bcd_to_ascii.sv
// -----------------------------------------------------------------------------
// bcd_to_ascii
// Combinational conversion of one BCD nibble to its ASCII digit.
//   nibble  in  4 : BCD digit
//   ascii   out 8 : '0'..'9', or '?' for a non-decimal nibble
//   invalid out 1 : nibble is greater than 9
// -----------------------------------------------------------------------------
module bcd_to_ascii
  import rtc_ascii_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii,
  output logic       invalid
);

  always_comb begin
    invalid = (nibble > 4'd9);
    ascii   = invalid ? ASCII_Q : (ASCII_0 + {4'h0, nibble});
  end

endmodule

// File: rtl/rtc_time_ascii.sv
// -----------------------------------------------------------------------------
// rtc_time_ascii
// Waits for the RTC's BCD time word to hold one new value for SETTLE_CYCLES
// cycles, snapshots it, and streams "HH:MM:SS" plus a line terminator as
// ASCII bytes over a valid/ready interface.
//
// Parameters
//   SETTLE_CYCLES : cycles data_in must hold one value before capture (1..65535)
//   SEP_CHAR      : byte placed between the hour/minute/second fields
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   data_in    in   24-bit BCD time {hours, minutes, seconds}
//   tx_data    out  current frame byte (8'h00 when no frame is in flight)
//   tx_valid   out  tx_data holds a byte to transfer
//   tx_ready   in   sink accepts the byte
//   busy       out  frame in flight
//   frame_done out  single-cycle pulse when the last byte is accepted
//   bcd_err    out  sticky: some captured nibble was not a decimal digit
//
// Handshake: a byte transfers on every rising clk edge where tx_valid and
// tx_ready are both high. Once tx_valid is raised it stays high, and tx_data
// stays constant, until that transfer happens.
//
// Build option: define RTC_TIME_ASCII_CRLF_EN for a CR LF terminator
// (10-byte frame); the default build ends each frame with LF only (9 bytes).
// -----------------------------------------------------------------------------
module rtc_time_ascii
  import rtc_ascii_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = 16'd1000,
  parameter logic [7:0]  SEP_CHAR      = 8'h3A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        bcd_err
);

  localparam logic [15:0]      STAB_MAX = SETTLE_CYCLES - 16'd1;
  localparam logic [IDX_W-1:0] LAST_IDX = FRAME_LEN - 4'd1;

  state_e           state_q, state_d;
  logic [23:0]      prev_in_q, prev_in_d;
  logic [23:0]      last_sent_q, last_sent_d;
  logic [23:0]      snap_q, snap_d;
  logic [15:0]      stab_cnt_q, stab_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             bcd_err_q, bcd_err_d;

  logic             in_stable;
  logic             capture;
  logic             handshake;
  logic             snap_bad;
  logic [7:0]       frame_byte;
  logic [7:0]       digit [6];
  logic [5:0]       dig_inv;

  // Digit g converts snap[4g+3:4g]: 5 = hour tens ... 0 = second units.
  for (genvar g = 0; g < 6; g++) begin : g_dig
    bcd_to_ascii u_bcd_to_ascii (
      .nibble  (snap_q[4*g +: 4]),
      .ascii   (digit[g]),
      .invalid (dig_inv[g])
    );
  end

  // Stability tracking runs in both states so that a value changing during
  // SEND is already settled (or settling) by the time the FSM returns.
  always_comb begin
    in_stable = (data_in == prev_in_q);
    prev_in_d = data_in;
    if (!in_stable) begin
      stab_cnt_d = 16'd0;
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 16'd1;
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
  end

  always_comb begin
    capture   = (state_q == IDLE) && in_stable && (stab_cnt_q == STAB_MAX) &&
                (data_in != last_sent_q);
    handshake = tx_valid && tx_ready;
    // Invalid digits are visible as soon as the snapshot drives the
    // converters, so the flag rises together with tx_valid.
    snap_bad  = (state_q == SEND) && (|dig_inv);
  end

  // Byte selection depends only on idx and the snapshot, which keeps tx_data
  // stable under backpressure.
  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      4'd0:    frame_byte = digit[5];
      4'd1:    frame_byte = digit[4];
      4'd2:    frame_byte = SEP_CHAR;
      4'd3:    frame_byte = digit[3];
      4'd4:    frame_byte = digit[2];
      4'd5:    frame_byte = SEP_CHAR;
      4'd6:    frame_byte = digit[1];
      4'd7:    frame_byte = digit[0];
`ifdef RTC_TIME_ASCII_CRLF_EN
      4'd8:    frame_byte = ASCII_CR;
      4'd9:    frame_byte = ASCII_LF;
`else
      4'd8:    frame_byte = ASCII_LF;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    last_sent_d = last_sent_q;
    bcd_err_d   = bcd_err_q | snap_bad;
    tx_valid    = 1'b0;
    busy        = 1'b0;
    tx_data     = 8'h00;
    frame_done  = 1'b0;
    bcd_err     = bcd_err_q | snap_bad;

    case (state_q)
      IDLE: begin
        if (capture) begin
          snap_d  = data_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = frame_byte;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            frame_done  = 1'b1;
            last_sent_d = snap_q;
            idx_d       = '0;
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // handshake only feeds the SEND branch through tx_ready; kept as a named
  // term for assertion binding.
  logic handshake_unused;
  assign handshake_unused = handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_in_q   <= 24'h000000;
      last_sent_q <= 24'hFFFFFF;
      snap_q      <= 24'h000000;
      stab_cnt_q  <= 16'd0;
      idx_q       <= '0;
      bcd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_in_q   <= prev_in_d;
      last_sent_q <= last_sent_d;
      snap_q      <= snap_d;
      stab_cnt_q  <= stab_cnt_d;
      idx_q       <= idx_d;
      bcd_err_q   <= bcd_err_d;
    end
  end

endmodule

// File: tb/tb_rtc_time_ascii.sv
// -----------------------------------------------------------------------------
// tb_rtc_time_ascii
// Scoreboard bench for rtc_time_ascii with SETTLE_CYCLES = 4.
// The reference model works on whole values: a value present at S+1
// consecutive clock edges that differs from the last value framed produces
// one ASCII frame, which is pushed into exp_q. A separate monitor pops and
// compares on every accepted byte.
// -----------------------------------------------------------------------------
module tb_rtc_time_ascii;

  localparam int          S      = 4;
  localparam logic [15:0] SETTLE = 16'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data_in = 24'h123456;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic        bcd_err;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rtc_time_ascii #(
    .SETTLE_CYCLES (SETTLE),
    .SEP_CHAR      (8'h3A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .bcd_err    (bcd_err)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  exp_q[$];          // {frame_has_bad_digit, last_byte, byte}
  logic [23:0] m_val;
  logic [23:0] m_last;
  int          m_run;
  logic        exp_err;
  int          hs_cnt = 0;
  int          bp_mode = 0;       // 0: ready high, 1: random, 2: manual
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [9:0]  mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_frame(input logic [23:0] v);
    logic [7:0] b[$];
    logic       bad;
    logic [3:0] n;
    bad = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      n = v[4*k +: 4];
      if (n <= 4'd9) b.push_back(8'h30 + {4'h0, n});
      else begin
        b.push_back(8'h3F);
        bad = 1'b1;
      end
      if (k == 4 || k == 2) b.push_back(8'h3A);
    end
`ifdef RTC_TIME_ASCII_CRLF_EN
    b.push_back(8'h0D);
`endif
    b.push_back(8'h0A);
    for (int i = 0; i < b.size(); i++)
      exp_q.push_back({bad, (i == b.size() - 1), b[i]});
  endfunction

  function automatic void model_reset();
    m_val   = 24'h000000;   // the input register clears to zero
    m_run   = 1;
    m_last  = 24'hFFFFFF;
    exp_err = 1'b0;
    exp_q.delete();
  endfunction

  // Account for one clock edge at which value v is present.
  function automatic void model_apply(input logic [23:0] v);
    if (v == m_val) m_run++;
    else begin
      m_val = v;
      m_run = 1;
    end
    if (m_run == S + 1 && v != m_last) begin
      push_frame(v);
      m_last = v;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic [23:0] v);
    @(negedge clk);
    data_in = v;
    model_apply(v);
  endtask

  task automatic drain(input logic [23:0] v);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 600) begin
      step(v);
      guard++;
    end
    if (guard != 0) check("drain_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic hold(input logic [23:0] v, input int n);
    repeat (n) step(v);
    drain(v);
  endtask

  task automatic wait_bytes(input logic [23:0] v, input int target);
    int guard;
    guard = 0;
    while (hs_cnt < target && guard < 200) begin
      step(v);
      guard++;
    end
    check("wait_bytes_timeout", (hs_cnt >= target), 1);
  endtask

  always @(negedge clk) begin
    if (bp_mode == 1) tx_ready = ($urandom_range(0, 1) == 1);
    else if (bp_mode == 0) tx_ready = 1'b1;
  end

  // ---------------- monitor ----------------
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: actual %02h required no byte (t=%0t)", tx_data, $time);
        end else begin
          mon_e   = exp_q.pop_front();
          exp_err = exp_err | mon_e[9];
          check("tx_data", tx_data, mon_e[7:0]);
          check("frame_done", frame_done, mon_e[8]);
          check("bcd_err", bcd_err, exp_err);
        end
      end else begin
        check("frame_done_no_xfer", frame_done, 0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_bcd_err"}, bcd_err, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [23:0] v;
    int          base;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");

    @(negedge clk);
    rst_n = 1'b1;
    model_apply(data_in);

    // Basic frame
    hold(24'h123456, S + 2);

    // Values that never settle produce nothing
    for (int i = 0; i < 10; i++) begin
      v = (i % 2 == 1) ? 24'h111111 : 24'h222222;
      repeat (3) step(v);
    end
    hold(24'h235959, S + 2);
    hold(24'h000000, S + 2);

    // Backpressure on byte 3 with a new value arriving mid-frame
    bp_mode  = 2;
    tx_ready = 1'b1;
    base     = hs_cnt;
    repeat (S + 1) step(24'h123456);
    wait_bytes(24'h123456, base + 3);
    tx_ready = 1'b0;
    repeat (5) step(24'h010203);
    check("stalled_byte3", tx_data, 8'h33);
    tx_ready = 1'b1;
    drain(24'h010203);
    bp_mode = 0;

    // Non-decimal digit and repeat suppression
    hold(24'h1A0000, S + 2);
    repeat (2) step(24'h1A0001);
    base = hs_cnt;
    hold(24'h1A0000, 20);
    check("no_repeat_frame", hs_cnt, base);
    check("bcd_err_sticky", bcd_err, 1);

    // Reset while byte 4 is on the bus
    base = hs_cnt;
    repeat (S + 1) step(24'h123456);
    wait_bytes(24'h123456, base + 4);
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_apply(data_in);
    base = hs_cnt;
    hold(24'h123456, S + 2);
`ifdef RTC_TIME_ASCII_CRLF_EN
    check("fresh_frame_len", hs_cnt - base, 10);
`else
    check("fresh_frame_len", hs_cnt - base, 9);
`endif

    // Randomized segments with random backpressure
    bp_mode = 1;
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom() & 24'hFFFFFF;
        1: v = m_last;
        default: begin
          v[23:20] = 4'($urandom_range(0, 2));
          v[19:16] = 4'($urandom_range(0, 9));
          v[15:12] = 4'($urandom_range(0, 5));
          v[11:8]  = 4'($urandom_range(0, 9));
          v[7:4]   = 4'($urandom_range(0, 5));
          v[3:0]   = 4'($urandom_range(0, 9));
        end
      endcase
      hold(v, $urandom_range(1, S + 3));
    end

    bp_mode = 0;
    hold(m_val, S + 2);
    check("final_idle", tx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
